// File: rtl/fsm_branch_jump_param.sv
// Purpose: control FSM sequencing conditional branches, JAL and JALR through decode, compare, writeback and misaligned-target trap.
// Latency: start->done is 5 cycles for jumps, 6 for branches (5 with FLAG_STAGE=0), plus 1 when a trap is taken.
// Backpressure: none; start is sampled only in IDLE and ignored everywhere else.
// Ports: clk/rst (async active-high); start, insn, code, rs1_val, rs2_val, target in;
//        datapath load enables, PC source selects, done/busy/trap_misaligned, branch_count/taken_count out.
module fsm_branch_jump_param #(
    parameter int XLEN       = 64,
    parameter int IALIGN     = 32,
    parameter int FLAG_STAGE = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      insn,
    input  logic [31:0]      code,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [XLEN-1:0]  target,
    output logic             load_rs1,
    output logic             load_rs2,
    output logic             load_imm,
    output logic             load_pc_alu,
    output logic             load_flags,
    output logic             load_regfile,
    output logic             load_pc,
    output logic             sel_pc_next,
    output logic             sel_pc_jump,
    output logic             sel_pc_increment,
    output logic             done,
    output logic             busy,
    output logic             trap_misaligned,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC_J = 4'd2;
    localparam logic [3:0] S_EXEC_B = 4'd3;
    localparam logic [3:0] S_FLAGS  = 4'd4;
    localparam logic [3:0] S_WB_J   = 4'd5;
    localparam logic [3:0] S_WB_B   = 4'd6;
    localparam logic [3:0] S_TRAP   = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       state_q, state_d;
    logic             eq_q, lt_q, ltu_q;
    logic [CNT_W-1:0] branch_cnt_q, taken_cnt_q;

    logic [2:0] funct3;
    logic       is_branch, is_jalr;
    logic       misaligned;
    logic       branch_taken;
    logic       taken;

    // Only funct3, the two class bits of code and the low target bits matter here.
    logic unused_bits;
    assign unused_bits = ^{insn, code, target};

    assign funct3    = insn[14:12];
    assign is_branch = code[24];
    assign is_jalr   = code[25];

    generate
        if (IALIGN == 16) begin : g_align16
            assign misaligned = target[0];
        end else begin : g_align32
            assign misaligned = |target[1:0];
        end
    endgenerate

    // Decided from flags captured in EXEC_B; funct3 010/011 are never taken.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = eq_q;
            3'b001:  branch_taken = ~eq_q;
            3'b100:  branch_taken = lt_q;
            3'b101:  branch_taken = ~lt_q;
            3'b110:  branch_taken = ltu_q;
            3'b111:  branch_taken = ~ltu_q;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        if (state_q == S_WB_J) taken = 1'b1;
        else if (state_q == S_WB_B) taken = branch_taken;
    end

    // Outputs are decoded from the registered state, so an async reset clears them in the same cycle.
    always_comb begin
        state_d          = S_IDLE;
        load_rs1         = 1'b0;
        load_rs2         = 1'b0;
        load_imm         = 1'b0;
        load_pc_alu      = 1'b0;
        load_flags       = 1'b0;
        load_regfile     = 1'b0;
        load_pc          = 1'b0;
        sel_pc_next      = 1'b0;
        sel_pc_jump      = 1'b0;
        sel_pc_increment = 1'b0;
        done             = 1'b0;
        busy             = 1'b1;
        trap_misaligned  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy    = 1'b0;
                state_d = start ? S_DECODE : S_IDLE;
            end
            S_DECODE: begin
                load_rs1 = 1'b1;
                load_rs2 = 1'b1;
                load_imm = 1'b1;
                state_d  = is_branch ? S_EXEC_B : S_EXEC_J;
            end
            S_EXEC_J: begin
                load_pc_alu = 1'b1;
                state_d     = S_WB_J;
            end
            S_EXEC_B: begin
                load_flags = 1'b1;
                state_d    = (FLAG_STAGE != 0) ? S_FLAGS : S_WB_B;
            end
            S_FLAGS: begin
                state_d = S_WB_B;
            end
            S_WB_J: begin
                if (misaligned) begin
                    state_d = S_TRAP;
                end else begin
                    load_regfile = 1'b1;
                    sel_pc_next  = 1'b1;
                    load_pc      = 1'b1;
                    sel_pc_jump  = ~is_jalr;
                    state_d      = S_DONE;
                end
            end
            S_WB_B: begin
                if (taken && misaligned) begin
                    state_d = S_TRAP;
                end else begin
                    load_pc          = 1'b1;
                    sel_pc_increment = taken;
                    state_d          = S_DONE;
                end
            end
            S_TRAP: begin
                trap_misaligned = 1'b1;
                state_d         = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            eq_q         <= 1'b0;
            lt_q         <= 1'b0;
            ltu_q        <= 1'b0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_EXEC_B) begin
                eq_q  <= (rs1_val == rs2_val);
                lt_q  <= ($signed(rs1_val) < $signed(rs2_val));
                ltu_q <= (rs1_val < rs2_val);
            end
            // Counted on leaving writeback, so trapped instructions are included.
            if (state_q == S_WB_B) branch_cnt_q <= branch_cnt_q + CNT_ONE;
            if (taken) taken_cnt_q <= taken_cnt_q + CNT_ONE;
        end
    end

    assign branch_count = branch_cnt_q;
    assign taken_count  = taken_cnt_q;

endmodule

// File: tb/tb_fsm_branch_jump_param.sv
// Purpose: directed self-checking bench for fsm_branch_jump_param (default build A, IALIGN=16/FLAG_STAGE=0 build B).
// Latency: inputs driven and outputs sampled on the falling clock edge; cycle 1 is the IDLE cycle with start high.
// Backpressure: not applicable.
module tb_fsm_branch_jump_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [31:0] insn, code;
    logic [63:0] rs1_val, rs2_val, target;

    logic a_rs1, a_rs2, a_imm, a_alu, a_flg, a_rf, a_pc, a_nxt, a_jmp, a_inc, a_done, a_busy, a_trap;
    logic b_rs1, b_rs2, b_imm, b_alu, b_flg, b_rf, b_pc, b_nxt, b_jmp, b_inc, b_done, b_busy, b_trap;
    logic [31:0] a_bcnt, a_tcnt, b_bcnt, b_tcnt;
    logic [12:0] ctl_a, ctl_b;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [12:0] RS1 = 13'h1000, RS2 = 13'h0800, IMM = 13'h0400, ALU = 13'h0200;
    localparam logic [12:0] FLG = 13'h0100, RF = 13'h0080, PC = 13'h0040, NXT = 13'h0020;
    localparam logic [12:0] JMP = 13'h0010, INC = 13'h0008, DN = 13'h0004, BSY = 13'h0002, TRP = 13'h0001;
    localparam logic [12:0] DEC = RS1 | RS2 | IMM | BSY;
    localparam logic [31:0] C_BR = 32'h0100_0000, C_JALR = 32'h0200_0000;

    always #5 clk = ~clk;

    assign ctl_a = {a_rs1, a_rs2, a_imm, a_alu, a_flg, a_rf, a_pc, a_nxt, a_jmp, a_inc, a_done, a_busy, a_trap};
    assign ctl_b = {b_rs1, b_rs2, b_imm, b_alu, b_flg, b_rf, b_pc, b_nxt, b_jmp, b_inc, b_done, b_busy, b_trap};

    fsm_branch_jump_param dut_a (
        .clk(clk), .rst(rst), .start(start_a), .insn(insn), .code(code),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .target(target),
        .load_rs1(a_rs1), .load_rs2(a_rs2), .load_imm(a_imm), .load_pc_alu(a_alu),
        .load_flags(a_flg), .load_regfile(a_rf), .load_pc(a_pc), .sel_pc_next(a_nxt),
        .sel_pc_jump(a_jmp), .sel_pc_increment(a_inc), .done(a_done), .busy(a_busy),
        .trap_misaligned(a_trap), .branch_count(a_bcnt), .taken_count(a_tcnt)
    );

    fsm_branch_jump_param #(.IALIGN(16), .FLAG_STAGE(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .insn(insn), .code(code),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .target(target),
        .load_rs1(b_rs1), .load_rs2(b_rs2), .load_imm(b_imm), .load_pc_alu(b_alu),
        .load_flags(b_flg), .load_regfile(b_rf), .load_pc(b_pc), .sel_pc_next(b_nxt),
        .sel_pc_jump(b_jmp), .sel_pc_increment(b_inc), .done(b_done), .busy(b_busy),
        .trap_misaligned(b_trap), .branch_count(b_bcnt), .taken_count(b_tcnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_op(input logic [31:0] c, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] t);
        code    = c;
        insn    = {17'h0, f3, 12'h063};
        rs1_val = a;
        rs2_val = b;
        target  = t;
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        set_op(32'h0, 3'b000, 64'h0, 64'h0, 64'h0);
        #1;
        chk("reset_ctl_a", ctl_a, 13'h0);
        chk("reset_ctl_b", ctl_b, 13'h0);
        chk("reset_bcnt", a_bcnt, 0);
        chk("reset_tcnt", a_tcnt, 0);
        tick(); rst = 1'b0;

        // BEQ taken, aligned, with the FLAGS wait state
        set_op(C_BR, 3'b000, 64'h5, 64'h5, 64'h1000); start_a = 1'b1;
        chk("beq_c1_idle", ctl_a, 13'h0);
        tick(); start_a = 1'b0; chk("beq_c2_dec", ctl_a, DEC);
        tick(); chk("beq_c3_execb", ctl_a, FLG | BSY);
        tick(); chk("beq_c4_flags", ctl_a, BSY);
        tick(); chk("beq_c5_wbb", ctl_a, PC | INC | BSY);
        tick(); chk("beq_c6_done", ctl_a, DN | BSY);
        chk("beq_bcnt", a_bcnt, 1); chk("beq_tcnt", a_tcnt, 1);
        tick(); chk("beq_c7_idle", ctl_a, 13'h0);

        // BLT signed taken; start held high the whole time must neither disturb nor skip IDLE
        set_op(C_BR, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1000); start_a = 1'b1;
        tick(); chk("blt_c2_dec", ctl_a, DEC);
        tick(); tick();
        chk("blt_c4_flags", ctl_a, BSY);
        tick(); chk("blt_c5_wbb", ctl_a, PC | INC | BSY);
        tick(); chk("blt_c6_done", ctl_a, DN | BSY);
        chk("blt_bcnt", a_bcnt, 2); chk("blt_tcnt", a_tcnt, 2);
        tick(); chk("blt_start_held_idle", ctl_a, 13'h0);
        start_a = 1'b0;
        tick(); chk("blt_idle_again", ctl_a, 13'h0);

        // BLTU same operands: not taken
        set_op(C_BR, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1000); start_a = 1'b1;
        tick(); start_a = 1'b0;
        tick(); tick(); tick();
        chk("bltu_c5_wbb", ctl_a, PC | BSY);
        tick(); chk("bltu_c6_done", ctl_a, DN | BSY);
        chk("bltu_bcnt", a_bcnt, 3); chk("bltu_tcnt", a_tcnt, 2);

        // JAL to 0x1002: trap on A (IALIGN=32), normal writeback on B (IALIGN=16)
        tick();
        set_op(32'h0, 3'b000, 64'h0, 64'h0, 64'h1002); start_a = 1'b1; start_b = 1'b1;
        tick(); start_a = 1'b0; start_b = 1'b0;
        chk("jal_c2_dec_a", ctl_a, DEC); chk("jal_c2_dec_b", ctl_b, DEC);
        tick(); chk("jal_c3_execj_a", ctl_a, ALU | BSY); chk("jal_c3_execj_b", ctl_b, ALU | BSY);
        tick(); chk("jal_c4_wbj_mis_a", ctl_a, BSY);
        chk("jal_c4_wbj_b", ctl_b, RF | PC | NXT | JMP | BSY);
        tick(); chk("jal_c5_trap_a", ctl_a, TRP | BSY); chk("jal_c5_done_b", ctl_b, DN | BSY);
        chk("jal_bcnt_b", b_bcnt, 0); chk("jal_tcnt_b", b_tcnt, 1);
        tick(); chk("jal_c6_done_a", ctl_a, DN | BSY);
        chk("jal_bcnt_a", a_bcnt, 3); chk("jal_tcnt_a", a_tcnt, 3);
        chk("jal_c6_idle_b", ctl_b, 13'h0);

        // JALR aligned
        tick();
        set_op(C_JALR, 3'b000, 64'h0, 64'h0, 64'h2000); start_a = 1'b1;
        tick(); start_a = 1'b0;
        tick(); tick(); chk("jalr_c4_wbj", ctl_a, RF | PC | NXT | BSY);
        tick(); chk("jalr_c5_done", ctl_a, DN | BSY);
        chk("jalr_tcnt", a_tcnt, 4);

        // Reset during FLAGS, then a BNE starting on the first edge after release
        tick();
        set_op(C_BR, 3'b001, 64'h5, 64'h5, 64'h1000); start_a = 1'b1;
        tick(); start_a = 1'b0;
        tick(); tick(); chk("rst_pre_flags", ctl_a, BSY);
        #2 rst = 1'b1;
        #1 chk("rst_mid_ctl", ctl_a, 13'h0);
        chk("rst_mid_bcnt", a_bcnt, 0); chk("rst_mid_tcnt", a_tcnt, 0);
        tick(); chk("rst_no_done", ctl_a, 13'h0);
        rst = 1'b0;
        set_op(C_BR, 3'b001, 64'h3, 64'h4, 64'h3000); start_a = 1'b1;
        tick(); start_a = 1'b0; chk("bne_c2_dec", ctl_a, DEC);
        tick(); tick(); tick(); chk("bne_c5_wbb", ctl_a, PC | INC | BSY);
        tick(); chk("bne_c6_done", ctl_a, DN | BSY);
        chk("bne_bcnt", a_bcnt, 1); chk("bne_tcnt", a_tcnt, 1);

        // funct3=010 with a misaligned target: never taken, never traps; B done at cycle 5
        tick();
        set_op(C_BR, 3'b010, 64'h7, 64'h7, 64'h1002); start_a = 1'b1; start_b = 1'b1;
        tick(); start_a = 1'b0; start_b = 1'b0;
        tick(); chk("f010_c3_execb_b", ctl_b, FLG | BSY);
        tick(); chk("f010_c4_wbb_b", ctl_b, PC | BSY); chk("f010_c4_flags_a", ctl_a, BSY);
        tick(); chk("f010_c5_done_b", ctl_b, DN | BSY); chk("f010_c5_wbb_a", ctl_a, PC | BSY);
        chk("f010_bcnt_b", b_bcnt, 1); chk("f010_tcnt_b", b_tcnt, 0);
        tick(); chk("f010_c6_done_a", ctl_a, DN | BSY);
        chk("f010_bcnt_a", a_bcnt, 2); chk("f010_tcnt_a", a_tcnt, 1);

        // Taken BEQ to a misaligned target: trap, still counted
        tick();
        set_op(C_BR, 3'b000, 64'h9, 64'h9, 64'h1001); start_a = 1'b1;
        tick(); start_a = 1'b0;
        tick(); tick(); tick(); chk("beqmis_c5_wbb", ctl_a, BSY);
        tick(); chk("beqmis_c6_trap", ctl_a, TRP | BSY);
        tick(); chk("beqmis_c7_done", ctl_a, DN | BSY);
        chk("beqmis_bcnt", a_bcnt, 3); chk("beqmis_tcnt", a_tcnt, 2);
        tick(); chk("beqmis_c8_idle", ctl_a, 13'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
